instr_fetch_stage: RTL and testbench

// Fetch stage feeding opcodeD into the decode-stage control unit. Owns the PC,

---
 rtl/instr_fetch_stage.sv | 138 +++++++++++++
 tb/tb_instr_fetch_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// ============================================================================
// instr_fetch_stage : PC owner, 1-cycle imem requester, IF/ID register + skid
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_fetch_stage #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    INSTR_WIDTH  = 32,
   parameter int                    OPCODE_WIDTH = 5,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    imem_req,
   output logic [ADDR_WIDTH-1:0]   imem_addr,
   input  logic [INSTR_WIDTH-1:0]  imem_rdata,
   input  logic                    stallD,
   input  logic                    flushD,
   input  logic                    branchTakenE,
   input  logic [ADDR_WIDTH-1:0]   branchTargetE,
   output logic [INSTR_WIDTH-1:0]  instrD,
   output logic [OPCODE_WIDTH-1:0] opcodeD,
   output logic [ADDR_WIDTH-1:0]   pcD,
   output logic                    validD
);

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   state_t                 state_q,       state_d;
   logic [ADDR_WIDTH-1:0]  pc_f_q,        pc_f_d;
   logic                   inflight_q,    inflight_d;
   logic [ADDR_WIDTH-1:0]  inflight_pc_q, inflight_pc_d;
   logic                   skid_valid_q,  skid_valid_d;
   logic [INSTR_WIDTH-1:0] skid_instr_q,  skid_instr_d;
   logic [ADDR_WIDTH-1:0]  skid_pc_q,     skid_pc_d;
   logic                   ifid_valid_q,  ifid_valid_d;
   logic [INSTR_WIDTH-1:0] ifid_instr_q,  ifid_instr_d;
   logic [ADDR_WIDTH-1:0]  ifid_pc_q,     ifid_pc_d;
   logic                   req_w;

   // A taken branch suppresses issue so no wrong-path word is ever requested.
   assign req_w = (state_q != BOOT) && !stallD && !branchTakenE;

   always_comb begin
      state_d       = state_q;
      pc_f_d        = pc_f_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      skid_valid_d  = skid_valid_q;
      skid_instr_d  = skid_instr_q;
      skid_pc_d     = skid_pc_q;
      ifid_valid_d  = ifid_valid_q;
      ifid_instr_d  = ifid_instr_q;
      ifid_pc_d     = ifid_pc_q;

      case (state_q)
         BOOT:    state_d = RUN;
         default: state_d = branchTakenE ? REDIRECT : RUN;
      endcase

      if (req_w) begin
         pc_f_d        = pc_f_q + ADDR_WIDTH'(4);
         inflight_d    = 1'b1;
         inflight_pc_d = pc_f_q;
      end

      if (branchTakenE) begin
         pc_f_d       = branchTargetE & ~ADDR_WIDTH'(3);
         skid_valid_d = 1'b0;
         ifid_valid_d = 1'b0;
      end else begin
         if (flushD) begin
            skid_valid_d = 1'b0;
            ifid_valid_d = 1'b0;
         end
         if (!stallD) begin
            // Skid and an in-flight response never coexist: stalls issue nothing.
            if (skid_valid_q && !flushD) begin
               ifid_valid_d = 1'b1;
               ifid_instr_d = skid_instr_q;
               ifid_pc_d    = skid_pc_q;
               skid_valid_d = 1'b0;
            end else if (inflight_q) begin
               ifid_valid_d = 1'b1;
               ifid_instr_d = imem_rdata;
               ifid_pc_d    = inflight_pc_q;
            end else begin
               ifid_valid_d = 1'b0;
            end
         end else if (inflight_q) begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = inflight_pc_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= BOOT;
         pc_f_q        <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         skid_valid_q  <= 1'b0;
         skid_instr_q  <= '0;
         skid_pc_q     <= '0;
         ifid_valid_q  <= 1'b0;
         ifid_instr_q  <= '0;
         ifid_pc_q     <= '0;
      end else begin
         state_q       <= state_d;
         pc_f_q        <= pc_f_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         skid_valid_q  <= skid_valid_d;
         skid_instr_q  <= skid_instr_d;
         skid_pc_q     <= skid_pc_d;
         ifid_valid_q  <= ifid_valid_d;
         ifid_instr_q  <= ifid_instr_d;
         ifid_pc_q     <= ifid_pc_d;
      end
   end

   assign imem_req  = req_w;
   assign imem_addr = pc_f_q;
   assign instrD    = ifid_instr_q;
   assign pcD       = ifid_pc_q;
   assign validD    = ifid_valid_q;
   assign opcodeD   = ifid_valid_q ? ifid_instr_q[INSTR_WIDTH-1 -: OPCODE_WIDTH] : '0;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
// ============================================================================
// tb_instr_fetch_stage : directed-vector bench for instr_fetch_stage
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stallD;
   logic        flushD;
   logic        branchTakenE;
   logic [31:0] branchTargetE;
   logic [31:0] instrD;
   logic [4:0]  opcodeD;
   logic [31:0] pcD;
   logic        validD;

   int vecs  = 0;
   int fails = 0;

   instr_fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .stallD        (stallD),
      .flushD        (flushD),
      .branchTakenE  (branchTakenE),
      .branchTargetE (branchTargetE),
      .instrD        (instrD),
      .opcodeD       (opcodeD),
      .pcD           (pcD),
      .validD        (validD)
   );

   always #5 clk = ~clk;

   // Memory word at address a is a + 0x10000000; unrequested cycles return junk.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= imem_addr + 32'h1000_0000;
      else          imem_rdata <= 32'hDEAD_BEEF;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in cycle 0: reset just released, DUT in BOOT.
   task automatic do_reset();
      rst = 1'b1; stallD = 1'b0; flushD = 1'b0;
      branchTakenE = 1'b0; branchTargetE = 32'h0;
      tick(); tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stallD = 1'b0; flushD = 1'b0;
      branchTakenE = 1'b0; branchTargetE = 32'h0;
      tick(); tick();
      vecs++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
      vecs++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
      vecs++; if (validD !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", validD); end
      vecs++; if ({instrD, pcD, opcodeD} !== 69'h0) begin fails++; $display("FAIL reset_regs: instr %h pc %h op %b want all 0", instrD, pcD, opcodeD); end
   endtask

   task automatic test_boot_latency();
      do_reset();
      vecs++; if (imem_req !== 1'b0) begin fails++; $display("FAIL boot_c0_req: got %b want 0", imem_req); end
      tick(); // cycle 1
      vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL boot_c1_req: req %b addr %h want 1 0", imem_req, imem_addr); end
      tick(); // cycle 2
      vecs++; if (validD !== 1'b0 || opcodeD !== 5'd0) begin fails++; $display("FAIL boot_c2_valid: valid %b op %b want 0 0", validD, opcodeD); end
      tick(); // cycle 3
      vecs++; if (validD !== 1'b1 || pcD !== 32'h0 || opcodeD !== 5'b00010 || instrD !== 32'h1000_0000) begin
         fails++; $display("FAIL boot_c3_first: valid %b pc %h op %b instr %h want 1 0 00010 10000000", validD, pcD, opcodeD, instrD);
      end
   endtask

   task automatic test_straight_line();
      logic [31:0] exp_pc;
      do_reset();
      tick(); tick(); tick(); // cycle 3
      for (int i = 0; i < 4; i++) begin
         exp_pc = 32'(i * 4);
         vecs++; if (validD !== 1'b1 || pcD !== exp_pc || instrD !== exp_pc + 32'h1000_0000) begin
            fails++; $display("FAIL straight_%0d: valid %b pc %h instr %h want 1 %h %h", i, validD, pcD, instrD, exp_pc, exp_pc + 32'h1000_0000);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      do_reset();
      tick(); tick(); tick(); tick(); // cycle 4: IF/ID @4, @8 in flight
      stallD = 1'b1; #1;
      vecs++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req: got %b want 0", imem_req); end
      tick(); tick(); // cycle 6
      vecs++; if (validD !== 1'b1 || pcD !== 32'h4) begin fails++; $display("FAIL stall_hold: valid %b pc %h want 1 4", validD, pcD); end
      tick(); // cycle 7
      stallD = 1'b0; #1;
      vecs++; if (pcD !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'hC) begin
         fails++; $display("FAIL stall_release: pc %h req %b addr %h want 4 1 c", pcD, imem_req, imem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         tick(); // cycles 8,9,10
         vecs++; if (validD !== 1'b1 || pcD !== 32'(8 + 4 * i)) begin
            fails++; $display("FAIL stall_after_%0d: valid %b pc %h want 1 %h", i, validD, pcD, 32'(8 + 4 * i));
         end
      end
   endtask

   task automatic test_branch();
      do_reset();
      tick(); tick(); tick(); tick(); // cycle 4
      stallD = 1'b1; branchTakenE = 1'b1; branchTargetE = 32'h41; #1;
      vecs++; if (imem_req !== 1'b0) begin fails++; $display("FAIL branch_req: got %b want 0", imem_req); end
      tick(); // cycle 5: REDIRECT
      branchTakenE = 1'b0; stallD = 1'b0; #1;
      vecs++; if (validD !== 1'b0 || imem_addr !== 32'h40 || imem_req !== 1'b1) begin
         fails++; $display("FAIL branch_redirect: valid %b addr %h req %b want 0 40 1", validD, imem_addr, imem_req);
      end
      tick(); // cycle 6
      vecs++; if (validD !== 1'b0) begin fails++; $display("FAIL branch_drop: valid %b pc %h want valid 0", validD, pcD); end
      tick(); // cycle 7
      vecs++; if (validD !== 1'b1 || pcD !== 32'h40 || instrD !== 32'h1000_0040) begin
         fails++; $display("FAIL branch_target: valid %b pc %h instr %h want 1 40 10000040", validD, pcD, instrD);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      tick(); tick(); tick(); tick(); // cycle 4
      branchTakenE = 1'b1; branchTargetE = 32'hFFFF_FFFC;
      tick(); // cycle 5
      branchTakenE = 1'b0; #1;
      vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_issue: req %b addr %h want 1 fffffffc", imem_req, imem_addr); end
      tick(); // cycle 6
      vecs++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
      tick(); // cycle 7
      vecs++; if (validD !== 1'b1 || pcD !== 32'hFFFF_FFFC || opcodeD !== 5'b00001) begin
         fails++; $display("FAIL wrap_top: valid %b pc %h op %b want 1 fffffffc 00001", validD, pcD, opcodeD);
      end
      tick(); // cycle 8
      vecs++; if (validD !== 1'b1 || pcD !== 32'h0) begin fails++; $display("FAIL wrap_zero: valid %b pc %h want 1 0", validD, pcD); end
   endtask

   task automatic test_flush();
      do_reset();
      tick(); tick(); tick(); tick(); // cycle 4
      stallD = 1'b1;
      tick(); // cycle 5: skid holds @8, nothing in flight
      flushD = 1'b1;
      tick(); // cycle 6
      flushD = 1'b0; stallD = 1'b0; #1;
      vecs++; if (validD !== 1'b0 || opcodeD !== 5'd0) begin fails++; $display("FAIL flush_kill: valid %b op %b want 0 0", validD, opcodeD); end
      vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin fails++; $display("FAIL flush_pc: req %b addr %h want 1 c", imem_req, imem_addr); end
      tick(); // cycle 7
      vecs++; if (validD !== 1'b0) begin fails++; $display("FAIL flush_skid: valid %b pc %h want valid 0", validD, pcD); end
      tick(); // cycle 8
      vecs++; if (validD !== 1'b1 || pcD !== 32'hC) begin fails++; $display("FAIL flush_resume: valid %b pc %h want 1 c", validD, pcD); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick(); tick(); tick(); tick(); // cycle 4
      stallD = 1'b1;
      tick(); // cycle 5: skid full
      rst = 1'b1;
      tick();
      stallD = 1'b0; #1;
      vecs++; if (validD !== 1'b0 || pcD !== 32'h0 || instrD !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b0) begin
         fails++; $display("FAIL midrst_regs: valid %b pc %h instr %h addr %h req %b want all 0", validD, pcD, instrD, imem_addr, imem_req);
      end
      rst = 1'b0;
      tick(); // cycle 1
      vecs++; if (validD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         fails++; $display("FAIL midrst_c1: valid %b req %b addr %h want 0 1 0", validD, imem_req, imem_addr);
      end
      tick(); // cycle 2
      vecs++; if (validD !== 1'b0) begin fails++; $display("FAIL midrst_c2: valid %b pc %h want valid 0", validD, pcD); end
      tick(); // cycle 3
      vecs++; if (validD !== 1'b1 || pcD !== 32'h0) begin fails++; $display("FAIL midrst_c3: valid %b pc %h want 1 0", validD, pcD); end
   endtask

   initial begin
      test_reset();
      test_boot_latency();
      test_straight_line();
      test_stall();
      test_branch();
      test_wrap();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule

`default_nettype wire
